// File: rtl/imem_line_responder.sv
// rtl/imem_line_responder.sv - backing instruction memory returning 4-word lines after a fixed latency
//
// Purpose: accepts one line-read request at a time and, LATENCY rising edges
// later, pulses resp_valid with the 128-bit line (word0 in the low 32 bits).
// A word-wide loader port writes program contents at any time.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_addr[31:0]           word address, line index = req_addr[31:2]
//   resp_valid               one-cycle response pulse
//   resp_line[127:0]         returned line, held until the next response
//   resp_err                 out-of-range line flag
//   ld_we/ld_addr/ld_data    loader word write
//
// Optional feature macro: IMEM_RANGE_CHECK_EN
//   defined   : out-of-range requests return resp_err=1 with a zero line,
//               out-of-range loader writes are dropped
//   undefined : line and word indices wrap, resp_err is always 0

module imem_line_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    output logic         resp_valid,
    output logic [127:0] resp_line,
    output logic         resp_err,
    input  logic         ld_we,
    input  logic [31:0]  ld_addr,
    input  logic [31:0]  ld_data
);

    localparam int LINES = DEPTH_WORDS / 4;
    localparam int WW    = $clog2(DEPTH_WORDS);
    // Keep the line index at least one bit wide even for a single-line array.
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CW    = $clog2(LATENCY + 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          state_q,      state_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [LW-1:0] idx_q,        idx_d;
    logic          err_q,        err_d;
    logic          resp_valid_q, resp_valid_d;
    logic [127:0]  resp_line_q,  resp_line_d;
    logic          resp_err_q,   resp_err_d;

    logic          req_oor;
    logic [LW-1:0] req_idx;
    logic          ld_en;
    logic [WW-1:0] ld_idx;
    logic [WW-1:0] rd_base;
    logic [127:0]  rd_line;

    logic          unused_bits;
    assign unused_bits = ^{req_addr, ld_addr};

    // Request index decode and loader write qualification.
    always_comb begin
        req_idx = LW'(req_addr[31:2] & 30'(LINES - 1));
        ld_idx  = ld_addr[WW-1:0];
`ifdef IMEM_RANGE_CHECK_EN
        req_oor = ({2'b00, req_addr[31:2]} >= 32'(LINES));
        ld_en   = ld_we && (ld_addr < 32'(DEPTH_WORDS));
`else
        req_oor = 1'b0;
        ld_en   = ld_we;
`endif
    end

    // Line read from the array contents before this edge's loader write,
    // which gives read-before-write on the response edge.
    always_comb begin
        rd_base = WW'({idx_q, 2'b00});
        rd_line = {mem_q[rd_base + WW'(3)], mem_q[rd_base + WW'(2)],
                   mem_q[rd_base + WW'(1)], mem_q[rd_base]};
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_line_d  = resp_line_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    // A counter of LATENCY-1 makes the response edge exactly
                    // LATENCY edges after the accept edge (LATENCY==1 included).
                    state_d = ST_BUSY;
                    cnt_d   = CW'(LATENCY - 1);
                    idx_d   = req_idx;
                    err_d   = req_oor;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_line_d  = err_q ? 128'd0 : rd_line;
                    resp_err_d   = err_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_line_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_line_q  <= resp_line_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Array contents survive reset; the loader may write in any state.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_line  = resp_line_q;
    assign resp_err   = resp_err_q;

endmodule
